// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - streams sprite bytes into image (and optional palette) RAM write ports
// Palette stage is built only when SPRITE_LOADER_PALETTE_EN is defined.
module sprite_loader #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  localparam int N     = WIDTH * HEIGHT,
  localparam int AW    = $clog2(N)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [7:0]    data_in,
  input  logic          data_valid_in,
  output logic          data_ready_out,
  output logic [AW-1:0] img_addr_out,
  output logic [7:0]    img_data_out,
  output logic          img_we_out,
  output logic [7:0]    plt_addr_out,
  output logic [23:0]   plt_data_out,
  output logic          plt_we_out,
  output logic          busy_out,
  output logic          done_out
);

`ifdef SPRITE_LOADER_PALETTE_EN
  typedef enum logic [1:0] {S_IDLE, S_PALETTE, S_PIXELS, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PIXELS, S_DONE} state_t;
`endif

  localparam logic [AW-1:0] PIX_LAST = AW'(N - 1);

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] pix_cnt_q, pix_cnt_d;
  logic [AW-1:0] img_addr_q, img_addr_d;
  logic [7:0]    img_data_q, img_data_d;
  logic          img_we_q, img_we_d;
  logic          done_q, done_d;
  logic          accept;

  assign accept = ready_q & data_valid_in;

`ifdef SPRITE_LOADER_PALETTE_EN
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  red_q, red_d, grn_q, grn_d;
  logic [7:0]  ent_q, ent_d;
  logic [7:0]  plt_addr_q, plt_addr_d;
  logic [23:0] plt_data_q, plt_data_d;
  logic        plt_we_q, plt_we_d;
`endif

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    pix_cnt_d  = pix_cnt_q;
    img_addr_d = img_addr_q;
    img_data_d = img_data_q;
    img_we_d   = 1'b0;
    done_d     = 1'b0;
`ifdef SPRITE_LOADER_PALETTE_EN
    sel_d      = sel_q;
    red_d      = red_q;
    grn_d      = grn_q;
    ent_d      = ent_q;
    plt_addr_d = plt_addr_q;
    plt_data_d = plt_data_q;
    plt_we_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          pix_cnt_d = '0;
          ready_d   = 1'b1;
`ifdef SPRITE_LOADER_PALETTE_EN
          sel_d     = 2'd0;
          ent_d     = 8'd0;
          state_d   = S_PALETTE;
`else
          state_d   = S_PIXELS;
`endif
        end
      end
`ifdef SPRITE_LOADER_PALETTE_EN
      S_PALETTE: begin
        if (accept) begin
          case (sel_q)
            2'd0: begin red_d = data_in; sel_d = 2'd1; end
            2'd1: begin grn_d = data_in; sel_d = 2'd2; end
            default: begin
              plt_we_d   = 1'b1;
              plt_addr_d = ent_q;
              plt_data_d = {red_q, grn_q, data_in};
              sel_d      = 2'd0;
              ent_d      = ent_q + 8'd1;
              if (ent_q == 8'hFF) state_d = S_PIXELS;
            end
          endcase
        end
      end
`endif
      S_PIXELS: begin
        if (accept) begin
          img_we_d   = 1'b1;
          img_addr_d = pix_cnt_q;
          img_data_d = data_in;
          // Last pixel: drop ready now so nothing beyond N-1 is ever taken.
          if (pix_cnt_q == PIX_LAST) begin
            ready_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pix_cnt_d = pix_cnt_q + AW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      pix_cnt_q  <= '0;
      img_addr_q <= '0;
      img_data_q <= 8'd0;
      img_we_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPRITE_LOADER_PALETTE_EN
      sel_q      <= 2'd0;
      red_q      <= 8'd0;
      grn_q      <= 8'd0;
      ent_q      <= 8'd0;
      plt_addr_q <= 8'd0;
      plt_data_q <= 24'd0;
      plt_we_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      pix_cnt_q  <= pix_cnt_d;
      img_addr_q <= img_addr_d;
      img_data_q <= img_data_d;
      img_we_q   <= img_we_d;
      done_q     <= done_d;
`ifdef SPRITE_LOADER_PALETTE_EN
      sel_q      <= sel_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      ent_q      <= ent_d;
      plt_addr_q <= plt_addr_d;
      plt_data_q <= plt_data_d;
      plt_we_q   <= plt_we_d;
`endif
    end
  end

  assign data_ready_out = ready_q;
  assign img_addr_out   = img_addr_q;
  assign img_data_out   = img_data_q;
  assign img_we_out     = img_we_q;
  assign busy_out       = (state_q != S_IDLE);
  assign done_out       = done_q;
`ifdef SPRITE_LOADER_PALETTE_EN
  assign plt_addr_out   = plt_addr_q;
  assign plt_data_out   = plt_data_q;
  assign plt_we_out     = plt_we_q;
`else
  assign plt_addr_out   = 8'd0;
  assign plt_data_out   = 24'd0;
  assign plt_we_out     = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - self-checking bench for sprite_loader (WIDTH=4, HEIGHT=2)
// Covers the SPRITE_LOADER_PALETTE_EN build when that macro is defined.
module tb_sprite_loader;
  localparam int N  = 8;
  localparam int AW = 3;
`ifdef SPRITE_LOADER_PALETTE_EN
  localparam int PAL = 768;
`else
  localparam int PAL = 0;
`endif

  typedef struct {int addr; int data; int cyc;} wr_t;

  logic          clk = 1'b0;
  logic          rst_n, start, valid;
  logic [7:0]    data;
  logic          ready, img_we, plt_we, busy, done;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_data, plt_addr;
  logic [23:0]   plt_data;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   plt_nz = 0;
  logic [7:0] stream [0:PAL+N-1];
  int   acc_cyc [$];
  wr_t  img_q [$];
  wr_t  plt_q [$];
  int   done_q [$];

  sprite_loader #(.WIDTH(4), .HEIGHT(2)) dut (
    .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start), .data_in(data),
    .data_valid_in(valid), .data_ready_out(ready), .img_addr_out(img_addr),
    .img_data_out(img_data), .img_we_out(img_we), .plt_addr_out(plt_addr),
    .plt_data_out(plt_data), .plt_we_out(plt_we), .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (img_we) img_q.push_back('{int'(img_addr), int'(img_data), cyc});
    if (plt_we) plt_q.push_back('{int'(plt_addr), int'(plt_data), cyc});
    if (done) done_q.push_back(cyc);
    if (plt_we || plt_addr != 8'd0 || plt_data != 24'd0) plt_nz++;
  end

  task automatic clear_logs();
    img_q.delete(); plt_q.delete(); done_q.delete(); acc_cyc.delete();
  endtask

  // Palette bytes random; pixel bytes either base+i or random when base < 0.
  task automatic fill_stream(input int base);
    for (int i = 0; i < PAL + N; i++) stream[i] = 8'($urandom);
    if (base >= 0) for (int i = 0; i < N; i++) stream[PAL+i] = 8'(base + i);
  endtask

  task automatic do_start(input bit start_valid);
    start = 1'b1; valid = start_valid; data = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0;
  endtask

  // mode 0: always valid, 1: valid pattern 1,0,0,1, 2: random valid
  task automatic drive(input int n, input int mode, input int start_at);
    int pat [4] = '{1, 0, 0, 1};
    int idx = 0, k = 0, budget = 4000;
    bit acc;
    while (idx < n && budget > 0) begin
      valid = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4][0] : 1'($urandom_range(0, 1));
      data  = stream[idx];
      start = (idx == start_at);
      @(negedge clk);
      acc = ready && valid;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (acc) idx++;
      k++; budget--;
    end
    valid = 1'b0; start = 1'b0;
    checks++;
    if (idx < n) begin
      errors++;
      $display("FAIL drive_timeout: accepted=%0d required=%0d", idx, n);
    end
  endtask

  task automatic run_load(input int mode, input int start_at, input bit start_valid);
    int t = 0;
    do_start(start_valid);
    drive(PAL + N, mode, start_at);
    do begin @(negedge clk); t++; end while (!done && t < 20);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_seen: done_out=%b required=1", done); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: busy_out=%b required=0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; data = 8'h00;
    #3;
    checks++;
    if ({ready, busy, img_we, done, img_addr, img_data} !== '0) begin
      errors++; $display("FAIL reset_img: got=%h required=0", {ready, busy, img_we, done, img_addr, img_data});
    end
    checks++;
    if ({plt_we, plt_addr, plt_data} !== '0) begin
      errors++; $display("FAIL reset_plt: got=%h required=0", {plt_we, plt_addr, plt_data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: ready,busy=%b required=00", {ready, busy}); end
  endtask

  task automatic test_back_to_back();
    clear_logs(); fill_stream(8'h10);
    run_load(0, -1, 1'b0);
    checks++;
    if (img_q.size() != N) begin errors++; $display("FAIL b2b_count: writes=%0d required=%0d", img_q.size(), N); end
    for (int i = 0; i < img_q.size() && i < N; i++) begin
      checks++;
      if (img_q[i].addr != i || img_q[i].data != 8'h10 + i || img_q[i].cyc != acc_cyc[PAL+i] + 1) begin
        errors++;
        $display("FAIL b2b_write[%0d]: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d", i,
                 img_q[i].addr, img_q[i].data, img_q[i].cyc, i, 8'h10 + i, acc_cyc[PAL+i] + 1);
      end
    end
    checks++;
    if (img_q.size() == N && img_q[N-1].cyc - img_q[0].cyc != N - 1) begin
      errors++; $display("FAIL b2b_span: cycles=%0d required=%0d", img_q[N-1].cyc - img_q[0].cyc, N - 1);
    end
    checks++;
    if (done_q.size() != 1 || img_q.size() != N || done_q[0] != img_q[N-1].cyc) begin
      errors++; $display("FAIL b2b_done: pulses=%0d required=1 at last write", done_q.size());
    end
    checks++;
    if (img_we !== 1'b0 || img_addr !== 3'd7 || img_data !== 8'h17) begin
      errors++; $display("FAIL b2b_hold: we=%b addr=%0d data=%h required we=0 addr=7 data=17", img_we, img_addr, img_data);
    end
  endtask

  task automatic test_stall();
    for (int mode = 1; mode <= 2; mode++) begin
      clear_logs(); fill_stream(-1);
      run_load(mode, -1, 1'b0);
      checks++;
      if (img_q.size() != N) begin errors++; $display("FAIL stall%0d_count: writes=%0d required=%0d", mode, img_q.size(), N); end
      for (int i = 0; i < img_q.size() && i < N; i++) begin
        checks++;
        if (img_q[i].addr != i || img_q[i].data != stream[PAL+i] || img_q[i].cyc != acc_cyc[PAL+i] + 1) begin
          errors++;
          $display("FAIL stall%0d_write[%0d]: addr=%0d data=%h required addr=%0d data=%h", mode, i,
                   img_q[i].addr, img_q[i].data, i, stream[PAL+i]);
        end
      end
      checks++;
      if (done_q.size() != 1) begin errors++; $display("FAIL stall%0d_done: pulses=%0d required=1", mode, done_q.size()); end
    end
  endtask

  task automatic test_start_ignored();
    clear_logs(); fill_stream(-1);
    run_load(0, PAL + 3, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (img_q.size() != N || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_writes: writes=%0d busy=%b required writes=%0d busy=0", img_q.size(), busy, N);
    end
    for (int i = 0; i < img_q.size() && i < N; i++) begin
      checks++;
      if (img_q[i].addr != i || img_q[i].data != stream[PAL+i]) begin
        errors++; $display("FAIL busy_start_write[%0d]: addr=%0d data=%h required addr=%0d data=%h", i,
                           img_q[i].addr, img_q[i].data, i, stream[PAL+i]);
      end
    end
    checks++;
    if (done_q.size() != 1) begin errors++; $display("FAIL busy_start_done: pulses=%0d required=1", done_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_logs(); fill_stream(-1);
    do_start(1'b0);
    drive(PAL + 6, 0, -1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, img_we, done, img_addr, img_data, plt_we} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got=%h required=0", {ready, busy, img_we, done, img_addr, img_data, plt_we});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_q.size() != 0 || img_q.size() != 6) begin
      errors++; $display("FAIL midreset_abandon: done=%0d writes=%0d required done=0 writes=6", done_q.size(), img_q.size());
    end
    @(posedge clk); #1;
    clear_logs(); fill_stream(-1);
    run_load(0, -1, 1'b0);
    checks++;
    if (img_q.size() != N) begin errors++; $display("FAIL midreset_reload_count: writes=%0d required=%0d", img_q.size(), N); end
    for (int i = 0; i < img_q.size() && i < N; i++) begin
      checks++;
      if (img_q[i].addr != i || img_q[i].data != stream[PAL+i]) begin
        errors++; $display("FAIL midreset_reload[%0d]: addr=%0d data=%h required addr=%0d data=%h", i,
                           img_q[i].addr, img_q[i].data, i, stream[PAL+i]);
      end
    end
  endtask

  task automatic test_idle_valid();
    int bad = 0;
    clear_logs();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1; data = 8'($urandom);
      @(negedge clk);
      if (ready || img_we || plt_we || busy) bad++;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    checks++;
    if (bad != 0 || img_q.size() != 0) begin
      errors++; $display("FAIL idle_valid: active_cycles=%0d writes=%0d required 0 and 0", bad, img_q.size());
    end
    clear_logs(); fill_stream(-1);
    run_load(0, -1, 1'b1);
    checks++;
    if (img_q.size() != N || img_q[0].data != stream[PAL] || img_q[0].addr != 0) begin
      errors++; $display("FAIL start_with_valid: writes=%0d first=%h required writes=%0d first=%h",
                         img_q.size(), img_q.size() ? img_q[0].data : -1, N, stream[PAL]);
    end
  endtask

  task automatic test_palette();
    clear_logs(); fill_stream(-1);
`ifdef SPRITE_LOADER_PALETTE_EN
    stream[0] = 8'hAA; stream[1] = 8'hBB; stream[2] = 8'hCC;
    run_load(2, -1, 1'b0);
    checks++;
    if (plt_q.size() != 256) begin errors++; $display("FAIL plt_count: writes=%0d required=256", plt_q.size()); end
    checks++;
    if (plt_q.size() == 0 || plt_q[0].addr != 0 || plt_q[0].data != 24'hAABBCC) begin
      errors++; $display("FAIL plt_first: data=%h required=aabbcc", plt_q.size() ? plt_q[0].data : -1);
    end
    for (int i = 0; i < plt_q.size() && i < 256; i++) begin
      checks++;
      if (plt_q[i].addr != i || plt_q[i].data != {stream[3*i], stream[3*i+1], stream[3*i+2]} ||
          plt_q[i].cyc != acc_cyc[3*i+2] + 1) begin
        errors++; $display("FAIL plt_entry[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, plt_q[i].addr,
                           plt_q[i].data, i, {stream[3*i], stream[3*i+1], stream[3*i+2]});
      end
    end
    checks++;
    if (img_q.size() != N || img_q[0].addr != 0 || img_q[0].data != stream[768]) begin
      errors++; $display("FAIL plt_then_pixel: writes=%0d required=%0d first at addr 0 data=%h", img_q.size(), N, stream[768]);
    end
`else
    plt_nz = 0;
    run_load(2, -1, 1'b0);
    checks++;
    if (plt_nz != 0 || plt_q.size() != 0 || img_q.size() != N) begin
      errors++; $display("FAIL no_palette: plt_active=%0d plt_writes=%0d img_writes=%0d required 0 0 %0d",
                         plt_nz, plt_q.size(), img_q.size(), N);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_idle_valid();
    test_palette();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 256: sprite width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 256: sprite height in pixels; N = WIDTH*HEIGHT, AW = $clog2(N).
REQ-003 SHALL have port pixel_clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start_in, input, 1: begin one load; sampled only in IDLE.
REQ-006 SHALL have port data_in, input, 8: stream byte.
REQ-007 SHALL have port data_valid_in, input, 1: data_in valid.
REQ-008 SHALL have port data_ready_out, output, 1: byte accepted when valid and ready are both high.
REQ-009 SHALL have port img_addr_out, output, AW: image RAM write address.
REQ-010 SHALL have port img_data_out, output, 8: palette index to write.
REQ-011 SHALL have port img_we_out, output, 1: image RAM write strobe.
REQ-012 SHALL have port plt_addr_out, output, 8: palette RAM write address.
REQ-013 SHALL have port plt_data_out, output, 24: {R,G,B} entry.
REQ-014 SHALL have port plt_we_out, output, 1: palette RAM write strobe.
REQ-015 SHALL have port busy_out, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done_out, output, 1: one-cycle pulse at load completion.

Function
REQ-017 SHALL implement the states IDLE, PALETTE (macro only), PIXELS and DONE.
REQ-018 SHALL, in IDLE with start_in=1, enter PALETTE if the macro is defined, else PIXELS; all counters are cleared on this transition.
REQ-019 SHALL drive data_ready_out as a registered signal that is high only in PALETTE and PIXELS; bytes offered in IDLE or DONE are not consumed.
REQ-020 SHALL, in PIXELS, assert img_we_out for exactly one cycle, the cycle after each accepted byte, with img_addr_out = pixel count (0..N-1) and img_data_out = the byte.
REQ-021 SHALL keep pixel addresses sequential with no gaps; valid low stalls the stream, inserts no write and does not advance the count.
REQ-022 SHALL, on accepting pixel N-1, clear data_ready_out on the next cycle and enter DONE; in DONE it presents the final write and asserts done_out, then returns to IDLE.
REQ-023 SHALL keep the pixel counter AW bits wide; it never wraps within a load, because the terminal compare is on N-1.
REQ-024 SHALL ignore start_in whenever busy_out=1.
REQ-025 SHALL, when start_in and data_valid_in are high in the same IDLE cycle, consume no byte in that cycle.
REQ-026 SHALL hold img_addr_out, img_data_out, plt_addr_out and plt_data_out at their last values when the associated strobe is low.

Reset
REQ-027 SHALL, with rst_in low, immediately force IDLE and set all outputs and counters to 0, regardless of clock.
REQ-028 SHALL, on reset mid-load, abandon the load with no done_out pulse and leave RAM contents already written untouched; the next load restarts at address 0.

Configuration
REQ-029 SHALL, with SPRITE_LOADER_PALETTE_EN defined, consume the first 768 bytes of each load as 256 palette entries of R,G,B before the pixel bytes.
REQ-030 SHALL, on each third palette byte, assert plt_we_out one cycle later with plt_addr_out = entry index (0..255) and plt_data_out = {R,G,B}; PALETTE then moves to PIXELS after entry 255.
REQ-031 SHALL, with SPRITE_LOADER_PALETTE_EN undefined, contain no palette logic, tie plt_we_out, plt_addr_out and plt_data_out to 0, and use only pixel bytes in the stream.

Verification (WIDTH=4, HEIGHT=2 unless noted)
REQ-032 SHALL cover: no macro, start then 8 back-to-back bytes 0x10..0x17 -> img writes at addr 0..7 with data 0x10..0x17, one per cycle lagging by 1, done_out high for 1 cycle after the last write appears, busy_out low the next cycle.
REQ-033 SHALL cover: valid toggled 1,0,0,1 during a load -> exactly one write per accepted byte, addresses contiguous, no duplicate strobes.
REQ-034 SHALL cover: start_in pulsed at pixel 3 -> no restart, addresses 4..7 follow, exactly one done_out pulse.
REQ-035 SHALL cover: rst_in low for 1 cycle after pixel 5 -> outputs 0 immediately, no done_out; a new start followed by 8 bytes -> writes at addr 0..7.
REQ-036 SHALL cover: macro defined, bytes 0xAA,0xBB,0xCC,... -> plt write addr 0 data 0xAABBCC; after 768 bytes, the first pixel byte is written to img addr 0.
REQ-037 SHALL cover: valid high in IDLE without start -> data_ready_out stays 0 and no strobes occur.
